dff_bit_readout: RTL and testbench
==================================

Name: dff_bit_readout

Overview:
- Per-bit write-enabled flip-flop bank plus the matching read side: a snapshot-and-serialize readout engine.
- Writers update individual bits of Q through independent enables.
- A readout request captures Q and a per-bit "written since reset" mask. It then shifts both out LSB-first over a valid/ready serial port.
- Used by the synthesis regression suite to read back enable-gated DFF state bit by bit.

Parameters:
- WIDTH, 4, number of register bits.
- IDX_W, 2, width of the bit index counter; must equal clog2(WIDTH), minimum 1.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  WIDTH  per-bit write enable.
- D  input  WIDTH  write data.
- Q  output  WIDTH  register contents.
- QV  output  WIDTH  bit i set once Q[i] has been written since reset.
- RD_REQ  input  1  start readout; sampled only when RD_BUSY=0.
- RD_BUSY  output  1  readout in progress.
- SO  output  1  serial data bit.
- SO_KNOWN  output  1  snapshot QV bit for the current SO.
- SO_VALID  output  1  serial beat valid.
- SO_READY  input  1  sink accepts beat.
- SO_LAST  output  1  final beat (index WIDTH-1).

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: Q=0, QV=0, FSM=IDLE, index=0, shadow registers=0; RD_BUSY, SO, SO_KNOWN, SO_VALID, SO_LAST all 0. Reset takes effect immediately, including mid-readout.
- Write path, every cycle, independent of the FSM:
  - For each i with EN[i]=1: Q[i] <= D[i] and QV[i] <= 1.
  - Bits with EN[i]=0 hold their value.
- FSM states: IDLE and SEND. All outputs are registered.
- IDLE:
  - On RD_REQ=1, snapshot shadow_q <= Q and shadow_v <= QV, using pre-edge values. A write in the same cycle is excluded from the snapshot.
  - Set index <= 0 and go to SEND.
  - With RD_REQ in cycle n, SO_VALID and RD_BUSY are high from cycle n+1.
- SEND:
  - SO_VALID=1, SO=shadow_q[index], SO_KNOWN=shadow_v[index], SO_LAST=(index==WIDTH-1).
  - On SO_VALID & SO_READY, if not last: index++ and the next beat is presented the following cycle.
  - On SO_VALID & SO_READY, if last: go to IDLE. SO_VALID, SO_LAST and RD_BUSY are 0 the next cycle.
  - While SO_READY=0: SO, SO_KNOWN, SO_LAST and SO_VALID hold stable and index does not advance.
- Throughput: with SO_READY held high, a readout takes exactly WIDTH beats in consecutive cycles.
- RD_REQ while RD_BUSY=1 is ignored, including in the final-handshake cycle. A new request is accepted only in IDLE.
- Writes during SEND update Q/QV normally and never alter the shadow registers.
- Index arithmetic is IDX_W bits unsigned. Index never exceeds WIDTH-1, and there is no wrap because SEND exits on the last beat.

Optional Feature:
- Macro: DFF_READOUT_CLEAR_ON_READ_EN.
- Defined: in the cycle a readout request is accepted, QV <= EN, i.e. all written flags are cleared except bits written in that same cycle.
  - The snapshot still captures the pre-clear QV.
  - Gives "written since last readout" semantics.
- Undefined: QV is only cleared by reset.

Decomposition:
- Package dff_readout_pkg holds:
  - state enum typedef (IDLE, SEND);
  - default WIDTH constant;
  - IDX_W derivation function (clog2).
- One sub-module: dff_bit_bank. It holds the per-bit enabled Q/QV registers, with an optional clear input driven by the readout FSM under the macro.
- The FSM, shadow registers and serial port stay in the top.

Test Plan (WIDTH=4):
- Reset, no writes, RD_REQ with SO_READY=1 -> Q=0000, QV=0000; 4 beats with SO=0 and SO_KNOWN=0; SO_LAST only on beat 4; RD_BUSY low the cycle after.
- Write sequence EN=0010/D=0000, then EN=0100/D=1111, then EN=1000/D=0000; then RD_REQ:
  - Q=0100, QV=1110.
  - Serial SO = 0,0,1,0.
  - SO_KNOWN = 0,1,1,1.
- Backpressure: SO_READY=0 for 3 cycles during beat 1 -> SO, SO_KNOWN and SO_VALID held stable; beat 2 appears only after the handshake; 7 cycles total.
- Write during readout: snapshot Q=0100, then EN=1111/D=1111 during beat 0 -> Q=1111 next cycle; stream still 0,0,1,0. RD_REQ pulsed in beat 2 is ignored (no second readout).
- Reset mid-readout: RST_N low during beat 2 -> SO_VALID, RD_BUSY, Q and QV are 0 immediately, without a clock edge. After release, a new RD_REQ starts at beat 0.
- With DFF_READOUT_CLEAR_ON_READ_EN: QV=1110, RD_REQ with EN=0001/D=1 in the same cycle -> QV=0001 next cycle; stream SO_KNOWN = 0,1,1,1.

Source files
------------

// File: rtl/dff_bit_readout_pkg.sv
// Shared types and constants for the dff_bit_readout slice: readout FSM state,
// default register width and the bit-index width helper.
package dff_readout_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Index counter needs at least one bit even for a 1- or 2-bit bank.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/dff_bit_readout_if.sv
// Valid/ready serial readout port of dff_bit_readout; the engine drives it
// through the master modport, the sink through the slave modport.
interface dff_bit_readout_if;

    logic SO;
    logic SO_KNOWN;
    logic SO_VALID;
    logic SO_READY;
    logic SO_LAST;

    modport master (
        output SO,
        output SO_KNOWN,
        output SO_VALID,
        output SO_LAST,
        input  SO_READY
    );

    modport slave (
        input  SO,
        input  SO_KNOWN,
        input  SO_VALID,
        input  SO_LAST,
        output SO_READY
    );

endinterface

// File: rtl/dff_bit_readout_bank.sv
// Per-bit write-enabled register bank with "written since reset/clear" flags.
// CLR replaces the flags with this cycle's enables instead of OR-ing them in.
module dff_bit_bank
    import dff_readout_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] EN,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QV
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q  <= '0;
            QV <= '0;
        end else begin
            Q  <= (Q & ~EN) | (D & EN);
            QV <= CLR ? EN : (QV | EN);
        end
    end

endmodule

// File: rtl/dff_bit_readout.sv
// Enable-gated DFF bank with snapshot-and-serialize LSB-first readout.
// Optional macro DFF_READOUT_CLEAR_ON_READ_EN: accepting a readout clears QV.
module dff_bit_readout
    import dff_readout_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [WIDTH-1:0]   EN,
    input  logic [WIDTH-1:0]   D,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   QV,
    input  logic               RD_REQ,
    output logic               RD_BUSY,
    dff_bit_readout_if.master  so
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nidx;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_v;
    logic             accept;
    logic             clr;

    assign accept = (state == IDLE) && RD_REQ;

`ifdef DFF_READOUT_CLEAR_ON_READ_EN
    assign clr = accept;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        nidx = idx + IDX_W'(1);
    end

    dff_bit_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .D     (D),
        .CLR   (clr),
        .Q     (Q),
        .QV    (QV)
    );

    // Beat 0 is presented straight from the live bank so it is valid the
    // cycle after the request; later beats come from the shadow copy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            idx         <= '0;
            shadow_q    <= '0;
            shadow_v    <= '0;
            RD_BUSY     <= 1'b0;
            so.SO       <= 1'b0;
            so.SO_KNOWN <= 1'b0;
            so.SO_VALID <= 1'b0;
            so.SO_LAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow_q    <= Q;
                        shadow_v    <= QV;
                        idx         <= '0;
                        state       <= SEND;
                        RD_BUSY     <= 1'b1;
                        so.SO       <= Q[0];
                        so.SO_KNOWN <= QV[0];
                        so.SO_VALID <= 1'b1;
                        so.SO_LAST  <= (WIDTH == 1);
                    end
                end
                SEND: begin
                    if (so.SO_READY) begin
                        if (idx == LAST_IDX) begin
                            state       <= IDLE;
                            idx         <= '0;
                            RD_BUSY     <= 1'b0;
                            so.SO       <= 1'b0;
                            so.SO_KNOWN <= 1'b0;
                            so.SO_VALID <= 1'b0;
                            so.SO_LAST  <= 1'b0;
                        end else begin
                            idx         <= nidx;
                            so.SO       <= shadow_q[nidx];
                            so.SO_KNOWN <= shadow_v[nidx];
                            so.SO_LAST  <= (nidx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bit_readout.sv
// Self-checking bench for dff_bit_readout (WIDTH=4): per-cycle behavioural
// model comparison plus directed readout scenarios with literal expectations.
module tb_dff_bit_readout;

    localparam int W = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] EN = '0;
    logic [3:0] D = '0;
    logic       RD_REQ = 1'b0;
    logic [3:0] Q;
    logic [3:0] QV;
    logic       RD_BUSY;

    dff_bit_readout_if sif ();

    dff_bit_readout #(
        .WIDTH (4),
        .IDX_W (2)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN      (EN),
        .D       (D),
        .Q       (Q),
        .QV      (QV),
        .RD_REQ  (RD_REQ),
        .RD_BUSY (RD_BUSY),
        .so      (sif.master)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, written flags and a snapshot
    // being streamed out at position mpos while mbusy.
    logic [3:0] mq = '0;
    logic [3:0] mqv = '0;
    logic [3:0] sq = '0;
    logic [3:0] sv = '0;
    logic       mbusy = 1'b0;
    int         mpos = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mq <= '0; mqv <= '0; sq <= '0; sv <= '0; mbusy <= 1'b0; mpos <= 0;
        end else begin
            if (!mbusy) begin
                if (RD_REQ) begin
                    sq <= mq; sv <= mqv; mbusy <= 1'b1; mpos <= 0;
                end
            end else if (sif.SO_READY) begin
                if (mpos == W - 1) begin
                    mbusy <= 1'b0; mpos <= 0;
                end else begin
                    mpos <= mpos + 1;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (EN[i]) begin
                    mq[i]  <= D[i];
                    mqv[i] <= 1'b1;
                end
`ifdef DFF_READOUT_CLEAR_ON_READ_EN
                else if (!mbusy && RD_REQ) begin
                    mqv[i] <= 1'b0;
                end
`endif
            end
        end
    end

    always @(negedge CLK) begin
        check("Q", Q, mq);
        check("QV", QV, mqv);
        check("RD_BUSY", RD_BUSY, mbusy);
        check("SO_VALID", sif.SO_VALID, mbusy);
        check("SO_LAST", sif.SO_LAST, mbusy && (mpos == W - 1));
        if (mbusy) begin
            check("SO", sif.SO, sq[mpos]);
            check("SO_KNOWN", sif.SO_KNOWN, sv[mpos]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues a request (with optional same-cycle write), then accepts all beats,
    // optionally stalling one beat, writing during one beat, and re-requesting
    // from req_beat onward. Records SO/SO_KNOWN/SO_LAST per beat index.
    task automatic readout(input logic [3:0] req_en, input logic [3:0] req_d,
                           input int stall_beat, input int stall_n,
                           input int wr_beat, input logic [3:0] wen, input logic [3:0] wd,
                           input int req_beat,
                           output logic [3:0] sb, output logic [3:0] kb,
                           output logic [3:0] lb, output int cyc);
        int   beat = 0;
        int   stalled = 0;
        logic wr_done = 1'b0;
        logic hs = 1'b0, hk = 1'b0, hv = 1'b0;
        sb = '0; kb = '0; lb = '0; cyc = 0;
        EN = req_en; D = req_d; RD_REQ = 1'b1; sif.SO_READY = 1'b1;
        tick();
        EN = '0; RD_REQ = 1'b0;
        while (beat < W && cyc < 40) begin
            RD_REQ = (beat >= req_beat);
            if (beat == wr_beat && !wr_done) begin
                EN = wen; D = wd; wr_done = 1'b1;
            end else begin
                EN = '0;
            end
            if (beat == stall_beat && stalled < stall_n) begin
                sif.SO_READY = 1'b0;
                if (stalled == 0) begin
                    hs = sif.SO; hk = sif.SO_KNOWN; hv = sif.SO_VALID;
                end else begin
                    check("stall_SO", sif.SO, hs);
                    check("stall_SO_KNOWN", sif.SO_KNOWN, hk);
                    check("stall_SO_VALID", sif.SO_VALID, hv);
                end
                stalled++;
            end else begin
                sif.SO_READY = 1'b1;
                if (sif.SO_VALID) begin
                    sb[beat] = sif.SO; kb[beat] = sif.SO_KNOWN; lb[beat] = sif.SO_LAST;
                    beat++;
                end
            end
            tick();
            cyc++;
        end
        EN = '0; RD_REQ = 1'b0; sif.SO_READY = 1'b1;
        check("readout_beats", beat, W);
    endtask

    logic [3:0] sb, kb, lb;
    int         cyc;

    initial begin
        sif.SO_READY = 1'b1;
        #1 RST_N = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
        check("rst_Q", Q, 4'b0000);
        check("rst_QV", QV, 4'b0000);
        check("rst_RD_BUSY", RD_BUSY, 1'b0);
        check("rst_SO_VALID", sif.SO_VALID, 1'b0);

        // Readout of an untouched bank.
        readout(4'b0000, 4'b0000, 99, 0, 99, 4'b0000, 4'b0000, 99, sb, kb, lb, cyc);
        check("t1_SO", sb, 4'b0000);
        check("t1_SO_KNOWN", kb, 4'b0000);
        check("t1_SO_LAST", lb, 4'b1000);
        check("t1_cycles", cyc, 4);
        check("t1_RD_BUSY_after", RD_BUSY, 1'b0);
        check("t1_SO_VALID_after", sif.SO_VALID, 1'b0);

        // Partial writes then readout.
        EN = 4'b0010; D = 4'b0000; tick();
        EN = 4'b0100; D = 4'b1111; tick();
        EN = 4'b1000; D = 4'b0000; tick();
        EN = 4'b0000;
        check("t2_Q", Q, 4'b0100);
        check("t2_QV", QV, 4'b1110);
        readout(4'b0000, 4'b0000, 99, 0, 99, 4'b0000, 4'b0000, 99, sb, kb, lb, cyc);
        check("t2_SO", sb, 4'b0100);
        check("t2_SO_KNOWN", kb, 4'b1110);
        check("t2_SO_LAST", lb, 4'b1000);

        // Backpressure: three stalled cycles on beat 1.
        readout(4'b0000, 4'b0000, 1, 3, 99, 4'b0000, 4'b0000, 99, sb, kb, lb, cyc);
        check("t3_SO", sb, 4'b0100);
`ifdef DFF_READOUT_CLEAR_ON_READ_EN
        check("t3_SO_KNOWN", kb, 4'b0000);
`else
        check("t3_SO_KNOWN", kb, 4'b1110);
`endif
        check("t3_cycles", cyc, 7);

        // Write during beat 0, extra requests from beat 2 to the end.
        readout(4'b0000, 4'b0000, 99, 0, 0, 4'b1111, 4'b1111, 2, sb, kb, lb, cyc);
        check("t4_SO", sb, 4'b0100);
`ifdef DFF_READOUT_CLEAR_ON_READ_EN
        check("t4_SO_KNOWN", kb, 4'b0000);
`else
        check("t4_SO_KNOWN", kb, 4'b1110);
`endif
        check("t4_Q", Q, 4'b1111);
        check("t4_QV", QV, 4'b1111);
        check("t4_RD_BUSY_after", RD_BUSY, 1'b0);
        tick();
        check("t4_no_second_RD_BUSY", RD_BUSY, 1'b0);
        check("t4_no_second_SO_VALID", sif.SO_VALID, 1'b0);

        // Asynchronous reset while beat 2 is on the port.
        RD_REQ = 1'b1; tick();
        RD_REQ = 1'b0; tick(); tick();
        check("t5_pre_SO_VALID", sif.SO_VALID, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check("t5_SO_VALID", sif.SO_VALID, 1'b0);
        check("t5_RD_BUSY", RD_BUSY, 1'b0);
        check("t5_Q", Q, 4'b0000);
        check("t5_QV", QV, 4'b0000);
        tick();
        RST_N = 1'b1;
        tick();
        EN = 4'b1111; D = 4'b0001; tick();
        EN = 4'b0000;
        readout(4'b0000, 4'b0000, 99, 0, 99, 4'b0000, 4'b0000, 99, sb, kb, lb, cyc);
        check("t5_SO", sb, 4'b0001);
        check("t5_SO_KNOWN", kb, 4'b1111);
        check("t5_SO_LAST", lb, 4'b1000);
        check("t5_cycles", cyc, 4);

        // Request accepted in the same cycle as a write to bit 0.
        RST_N = 1'b0; tick();
        RST_N = 1'b1; tick();
        EN = 4'b1110; D = 4'b0100; tick();
        EN = 4'b0000;
        check("t6_QV_before", QV, 4'b1110);
        readout(4'b0001, 4'b0001, 99, 0, 99, 4'b0000, 4'b0000, 99, sb, kb, lb, cyc);
        check("t6_SO", sb, 4'b0100);
        check("t6_SO_KNOWN", kb, 4'b1110);
        check("t6_Q", Q, 4'b0101);
`ifdef DFF_READOUT_CLEAR_ON_READ_EN
        check("t6_QV", QV, 4'b0001);
`else
        check("t6_QV", QV, 4'b1111);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, actual running required finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
